trap_controller: RTL

Machine-mode trap and return sequencer driving `trap_taken` and `mret_exec` into the pipeline controller. It qualifies exceptions, MRET and interrupts against the instruction in EXE. It owns the machine trap CSRs and supplies the redirect PC. It sits beside the EXE stage and is the producer side of the pipeline controller's trap/return flush interface.

---
 rtl/trap_pkg.sv | 39 +++
 rtl/trap_controller_if.sv | 44 ++++
 rtl/trap_csr_regs.sv | 127 ++++++++++++
 rtl/trap_controller.sv | 132 +++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared constants and types for the machine-mode trap
//                controller: CSR addresses, mcause codes, mstatus/mie bit
//                positions and the commit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    // Machine trap CSR addresses
    localparam logic [11:0] c_csr_mstatus = 12'h300;
    localparam logic [11:0] c_csr_mie     = 12'h304;
    localparam logic [11:0] c_csr_mtvec   = 12'h305;
    localparam logic [11:0] c_csr_mepc    = 12'h341;
    localparam logic [11:0] c_csr_mcause  = 12'h342;
    localparam logic [11:0] c_csr_mip     = 12'h344;

    // mcause values; bit 31 flags an interrupt
    localparam logic [31:0] c_cause_illegal   = 32'h0000_0002;
    localparam logic [31:0] c_cause_ebreak    = 32'h0000_0003;
    localparam logic [31:0] c_cause_ecall     = 32'h0000_000B;
    localparam logic [31:0] c_cause_irq_ext   = 32'h8000_000B;
    localparam logic [31:0] c_cause_irq_timer = 32'h8000_0007;

    // mstatus / mie / mip bit positions
    localparam int c_mstatus_mie  = 3;
    localparam int c_mstatus_mpie = 7;
    localparam int c_mie_meie     = 11;
    localparam int c_mie_mtie     = 7;

    // Commit FSM: BLANK is the single dead cycle after any commit
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/trap_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller_if
//  Description : EXE-stage / CSR / commit bundle between the pipeline
//                (master) and the trap controller (slave).
//                master drives: stall_pipl, exe_*, irq_*, csr_addr/we/wdata
//                slave drives : csr_rdata, trap_taken, mret_exec, redirect_pc
//  Revision    : 1.0 - initial release
// ============================================================================
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            stall_pipl;
    logic            exe_valid;
    logic [XLEN-1:0] exe_pc;
    logic            exe_illegal;
    logic            exe_ecall;
    logic            exe_ebreak;
    logic            exe_mret;
    logic            irq_ext;
    logic            irq_timer;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            trap_taken;
    logic            mret_exec;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output stall_pipl, exe_valid, exe_pc, exe_illegal, exe_ecall,
               exe_ebreak, exe_mret, irq_ext, irq_timer,
               csr_addr, csr_we, csr_wdata,
        input  csr_rdata, trap_taken, mret_exec, redirect_pc
    );

    modport slave (
        input  stall_pipl, exe_valid, exe_pc, exe_illegal, exe_ecall,
               exe_ebreak, exe_mret, irq_ext, irq_timer,
               csr_addr, csr_we, csr_wdata,
        output csr_rdata, trap_taken, mret_exec, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/trap_csr_regs.sv
`default_nettype none
// ============================================================================
//  Module      : trap_csr_regs
//  Description : Machine trap CSR storage (mstatus, mie, mtvec, mepc, mcause)
//                and combinational read mux (mip is assembled from inputs).
//                Ports: i_clk/i_reset, CSR write/read port (i_csr_we must be
//                pre-qualified by the caller), trap/mret commit strobes with
//                cause and EPC, MEIP/MTIP levels, and the enable/vector state
//                the sequencer needs.
//                Macro TRAP_VECTORED_EN keeps mtvec[0] writable.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_csr_regs
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    input  wire logic [11:0]     i_csr_addr,
    input  wire logic            i_csr_we,
    input  wire logic [XLEN-1:0] i_csr_wdata,
    output logic      [XLEN-1:0] o_csr_rdata,
    input  wire logic            i_trap_commit,
    input  wire logic [XLEN-1:0] i_trap_cause,
    input  wire logic [XLEN-1:0] i_trap_epc,
    input  wire logic            i_mret_commit,
    input  wire logic            i_meip,
    input  wire logic            i_mtip,
    output logic                 o_mstatus_mie,
    output logic                 o_mie_meie,
    output logic                 o_mie_mtie,
    output logic      [XLEN-1:0] o_mtvec,
    output logic      [XLEN-1:0] o_mepc
);

`ifdef TRAP_VECTORED_EN
    localparam logic [XLEN-1:0] c_mtvec_mask = ~XLEN'(2);
`else
    localparam logic [XLEN-1:0] c_mtvec_mask = ~XLEN'(3);
`endif
    localparam logic [XLEN-1:0] c_mepc_mask = ~XLEN'(3);

    logic            r_mie;
    logic            r_mpie;
    logic            r_meie;
    logic            r_mtie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic            w_commit;
    logic [XLEN-1:0] w_rdata;

    assign w_commit = i_trap_commit | i_mret_commit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_meie   <= 1'b0;
            r_mtie   <= 1'b0;
            r_mtvec  <= MTVEC_RESET & c_mtvec_mask;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            // mie/mtvec writes are independent of commits; mstatus, mepc
            // and mcause writes lose to a commit in the same cycle.
            if (i_csr_we) begin
                case (i_csr_addr)
                    c_csr_mie: begin
                        r_meie <= i_csr_wdata[c_mie_meie];
                        r_mtie <= i_csr_wdata[c_mie_mtie];
                    end
                    c_csr_mtvec:   r_mtvec <= i_csr_wdata & c_mtvec_mask;
                    c_csr_mstatus: if (!w_commit) begin
                        r_mie  <= i_csr_wdata[c_mstatus_mie];
                        r_mpie <= i_csr_wdata[c_mstatus_mpie];
                    end
                    c_csr_mepc:    if (!w_commit) r_mepc   <= i_csr_wdata & c_mepc_mask;
                    c_csr_mcause:  if (!w_commit) r_mcause <= i_csr_wdata;
                    default: ;
                endcase
            end
            if (i_trap_commit) begin
                r_mepc   <= i_trap_epc & c_mepc_mask;
                r_mcause <= i_trap_cause;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (i_mret_commit) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_csr_addr)
            c_csr_mstatus: begin
                w_rdata[c_mstatus_mie]  = r_mie;
                w_rdata[c_mstatus_mpie] = r_mpie;
            end
            c_csr_mie: begin
                w_rdata[c_mie_meie] = r_meie;
                w_rdata[c_mie_mtie] = r_mtie;
            end
            c_csr_mip: begin
                w_rdata[c_mie_meie] = i_meip;
                w_rdata[c_mie_mtie] = i_mtip;
            end
            c_csr_mtvec:  w_rdata = r_mtvec;
            c_csr_mepc:   w_rdata = r_mepc;
            c_csr_mcause: w_rdata = r_mcause;
            default:      w_rdata = '0;
        endcase
    end

    assign o_csr_rdata   = w_rdata;
    assign o_mstatus_mie = r_mie;
    assign o_mie_meie    = r_meie;
    assign o_mie_mtie    = r_mtie;
    assign o_mtvec       = r_mtvec;
    assign o_mepc        = r_mepc;

endmodule
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller
//  Description : Machine-mode trap/MRET sequencer. Qualifies exceptions,
//                interrupts and MRET against the EXE instruction, emits a
//                same-cycle trap_taken / mret_exec pulse with redirect_pc,
//                then blanks one cycle.
//                Ports: clk, reset (async, active-high), bus (slave side of
//                trap_controller_if: EXE flags, irqs, CSR port, commit out).
//                Macro TRAP_VECTORED_EN enables vectored interrupt dispatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_controller
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    trap_controller_if.slave  bus
);

    state_t          r_state;
    state_t          w_state_next;
    logic            r_irq_sync1;
    logic            r_irq_sync2;
    logic            w_mie;
    logic            w_meie;
    logic            w_mtie;
    logic [XLEN-1:0] w_mtvec;
    logic [XLEN-1:0] w_mepc;
    logic            w_exc;
    logic            w_irq_ext_ok;
    logic            w_irq_tmr_ok;
    logic            w_trap;
    logic            w_mret;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_target;
    logic            w_csr_we;

    // CSR writes are frozen while the pipeline is stalled
    assign w_csr_we = bus.csr_we & ~bus.stall_pipl;

    trap_csr_regs #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_csr_addr    (bus.csr_addr),
        .i_csr_we      (w_csr_we),
        .i_csr_wdata   (bus.csr_wdata),
        .o_csr_rdata   (bus.csr_rdata),
        .i_trap_commit (w_trap),
        .i_trap_cause  (w_cause),
        .i_trap_epc    (bus.exe_pc),
        .i_mret_commit (w_mret),
        .i_meip        (r_irq_sync2),
        .i_mtip        (bus.irq_timer),
        .o_mstatus_mie (w_mie),
        .o_mie_meie    (w_meie),
        .o_mie_mtie    (w_mtie),
        .o_mtvec       (w_mtvec),
        .o_mepc        (w_mepc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_irq_sync1 <= 1'b0;
            r_irq_sync2 <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_irq_sync1 <= bus.irq_ext;
            r_irq_sync2 <= r_irq_sync1;
        end
    end

    assign w_exc        = bus.exe_valid & (bus.exe_illegal | bus.exe_ebreak | bus.exe_ecall);
    assign w_irq_ext_ok = bus.exe_valid & w_mie & w_meie & r_irq_sync2;
    assign w_irq_tmr_ok = bus.exe_valid & w_mie & w_mtie & bus.irq_timer;

    // Mealy commit: pulses are gated by reset so they drop asynchronously
    always_comb begin
        w_state_next = r_state;
        w_trap       = 1'b0;
        w_mret       = 1'b0;
        w_cause      = '0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.stall_pipl && !reset) begin
                    if (w_exc) begin
                        w_trap = 1'b1;
                        if (bus.exe_illegal)     w_cause = XLEN'(c_cause_illegal);
                        else if (bus.exe_ebreak) w_cause = XLEN'(c_cause_ebreak);
                        else                     w_cause = XLEN'(c_cause_ecall);
                    end else if (w_irq_ext_ok) begin
                        w_trap  = 1'b1;
                        w_cause = XLEN'(c_cause_irq_ext);
                    end else if (w_irq_tmr_ok) begin
                        w_trap  = 1'b1;
                        w_cause = XLEN'(c_cause_irq_timer);
                    end else if (bus.exe_valid && bus.exe_mret) begin
                        w_mret = 1'b1;
                    end
                    if (w_trap || w_mret) w_state_next = ST_BLANK;
                end
            end
            ST_BLANK: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_base = {w_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Only interrupts (cause MSB set) use the vector table
    assign w_target = (w_mtvec[0] && w_cause[XLEN-1])
                    ? w_base + {w_cause[XLEN-3:0], 2'b00}
                    : w_base;
`else
    assign w_target = w_base;
`endif

    assign bus.trap_taken  = w_trap;
    assign bus.mret_exec   = w_mret;
    assign bus.redirect_pc = w_trap ? w_target : (w_mret ? w_mepc : '0);

endmodule
`default_nettype wire
